// File: rtl/opl2_host_if_if.sv
// rtl/opl2_host_if_if.sv - OPL2 host bus and register-write stream interface plus payload type
//
// Purpose: bundles the host-side bus and the opl2_reg_wr stream of opl2_host_if.
// Signals:
//   host_wr     host -> core   one-cycle write strobe
//   host_rd     host -> core   one-cycle read strobe
//   a0          host -> core   0 = address/status port, 1 = data port
//   din[7:0]    host -> core   host write data
//   dout[7:0]   core -> host   registered status byte
//   opl2_reg_wr core -> OPL2   {valid, address[7:0], data[7:0]} register-write pulse
// Modports: master (host side), slave (opl2_host_if).

package opl2_host_pkg;
  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] data;
  } opl2_reg_wr_t;
endpackage

interface opl2_host_if_if;
  import opl2_host_pkg::*;

  logic         host_wr;
  logic         host_rd;
  logic         a0;
  logic [7:0]   din;
  logic [7:0]   dout;
  opl2_reg_wr_t opl2_reg_wr;

  modport master (
    output host_wr, host_rd, a0, din,
    input  dout, opl2_reg_wr
  );

  modport slave (
    input  host_wr, host_rd, a0, din,
    output dout, opl2_reg_wr
  );
endinterface

// File: rtl/opl2_host_if.sv
// rtl/opl2_host_if.sv - OPL2 host register-write front end with buffered, rate-limited drain
//
// Purpose: decodes the two-port host bus (a0 selects address/status or data),
// queues completed register writes and drains them as single-cycle
// opl2_reg_wr pulses spaced WR_SPACING clocks apart.
// Ports:
//   clk    core clock
//   reset  asynchronous active-high reset
//   bus    opl2_host_if_if.slave: host_wr, host_rd, a0, din in; dout, opl2_reg_wr out
// Parameters:
//   FIFO_DEPTH  write FIFO entries (power of two, >= 2)
//   WR_SPACING  minimum clocks between opl2_reg_wr.valid pulses (>= 2)
// Configuration macro: OPL2_HOST_WR_FIFO_EN
//   defined   -> FIFO_DEPTH-entry write FIFO
//   undefined -> single holding register (FIFO_DEPTH unused)

module opl2_host_if
  import opl2_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WR_SPACING = 32
) (
  input  logic          clk,
  input  logic          reset,
  opl2_host_if_if.slave bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("opl2_host_if: FIFO_DEPTH must be a power of two >= 2");
  end
  if (WR_SPACING < 2) begin : g_bad_spacing
    $error("opl2_host_if: WR_SPACING must be >= 2");
  end

  localparam int               CNT_W    = $clog2(WR_SPACING + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WR_SPACING - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  // Host strobe decode
  logic wr_addr;
  logic wr_data;
  logic rd_status;

  assign wr_addr   = bus.host_wr && !bus.a0;
  assign wr_data   = bus.host_wr &&  bus.a0;
  assign rd_status = bus.host_rd && !bus.a0;

  // Buffer status and head, common to both buffer builds
  logic       full;
  logic       empty;
  logic       push_ok;
  logic       pop;
  logic       overflow;
  logic [7:0] head_addr;
  logic [7:0] head_data;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       addr_latch_q, addr_latch_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       last_addr_q, last_addr_d;
  logic [7:0]       last_data_q, last_data_d;

  // The head is consumed in the one cycle the FSM spends in ISSUE.
  assign pop      = (state_q == S_ISSUE);
  assign overflow = wr_data && !push_ok;

`ifdef OPL2_HOST_WR_FIFO_EN
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [FIFO_DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // full is taken pre-pop: a full FIFO rejects a push even while it pops.
  assign push_ok = wr_data && !full;

  assign wr_ptr_d = push_ok ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
  assign rd_ptr_d = pop     ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

  assign {head_addr, head_data} = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= {addr_latch_q, bus.din};
    end
  end
`else
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_q, hold_d;

  assign full    = hold_valid_q;
  assign empty   = !hold_valid_q;
  // The register frees up in its own ISSUE cycle, so a push there is accepted.
  assign push_ok = wr_data && (!hold_valid_q || pop);

  assign {head_addr, head_data} = hold_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (push_ok) begin
      hold_valid_d = 1'b1;
      hold_d       = {addr_latch_q, bus.din};
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end
`endif

  // Host-side registers: address latch, sticky overflow, status byte
  always_comb begin
    addr_latch_d = addr_latch_q;
    ovf_d        = ovf_q;
    dout_d       = dout_q;

    if (wr_addr) begin
      addr_latch_d = bus.din;
    end

    // An overflow in the same cycle as a status read keeps ovf set.
    if (overflow) begin
      ovf_d = 1'b1;
    end else if (rd_status) begin
      ovf_d = 1'b0;
    end

    // Status reflects registered state from before this cycle's push/pop.
    if (bus.host_rd) begin
      dout_d = bus.a0 ? 8'h00 : {5'b00000, ovf_q, empty, full};
    end
  end

  // Drain FSM
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        last_addr_d = head_addr;
        last_data_d = head_data;
        gap_cnt_d   = GAP_LOAD;
        state_d     = S_GAP;
      end
      S_GAP: begin
        // Leaving on a count of 1 leaves room for the IDLE cycle, so
        // ISSUE + GAP cycles + IDLE add up to WR_SPACING. With a load of 0
        // one GAP cycle is still spent.
        gap_cnt_d = (gap_cnt_q == '0) ? '0 : (gap_cnt_q - CNT_W'(1));
        if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gap_cnt_q    <= '0;
      addr_latch_q <= '0;
      ovf_q        <= 1'b0;
      dout_q       <= '0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      addr_latch_q <= addr_latch_d;
      ovf_q        <= ovf_d;
      dout_q       <= dout_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
    end
  end

  // Outside ISSUE the address/data fields hold the last issued values.
  opl2_reg_wr_t reg_wr;

  always_comb begin
    reg_wr         = '0;
    reg_wr.valid   = pop;
    reg_wr.address = pop ? head_addr : last_addr_q;
    reg_wr.data    = pop ? head_data : last_data_q;
  end

  assign bus.opl2_reg_wr = reg_wr;
  assign bus.dout        = dout_q;

endmodule

// File: tb/tb_opl2_host_if.sv
// tb/tb_opl2_host_if.sv - self-checking bench for opl2_host_if

module tb_opl2_host_if;
  import opl2_host_pkg::*;

  localparam int W  = 32;
  localparam int FD = 8;
`ifdef OPL2_HOST_WR_FIFO_EN
  localparam int  EFF  = FD;
  localparam bit  HOLD = 1'b0;
`else
  localparam int  EFF  = 1;
  localparam bit  HOLD = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  opl2_host_if_if bus ();

  opl2_host_if #(
    .FIFO_DEPTH(FD),
    .WR_SPACING(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: every accepted write with the cycle it entered and the cycle it must issue.
  typedef struct {
    int         push_t;
    int         issue_t;
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  typedef struct {
    int         at;
    logic [7:0] v;
  } pend_t;

  ent_t       q[$];
  pend_t      pend[$];
  int         last_issue = -100000;
  logic [7:0] addr_m = 8'h00;
  logic       ovf_m = 1'b0;
  logic [7:0] dout_exp = 8'h00;

  int         pulse_t[$];
  logic [7:0] pulse_d[$];

  int checks = 0;
  int fails  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // Entries sitting in the buffer during cycle c (popped at the end of their issue cycle).
  function automatic int occ_at(input int c);
    int n = 0;
    foreach (q[i]) if (q[i].push_t < c && q[i].issue_t >= c) n++;
    return n;
  endfunction

  function automatic int issuing_at(input int c);
    int n = 0;
    foreach (q[i]) if (q[i].issue_t == c) n++;
    return n;
  endfunction

  task automatic step(input logic wr, input logic rd, input logic a, input logic [7:0] d);
    int c;
    int occ;
    int credit;
    bit drop;
    @(negedge clk);
    bus.host_wr = wr;
    bus.host_rd = rd;
    bus.a0      = a;
    bus.din     = d;
    c      = cyc;
    occ    = occ_at(c);
    credit = HOLD ? issuing_at(c) : 0;
    drop   = 1'b0;
    if (rd) begin
      pend_t p;
      p.at = c + 1;
      p.v  = a ? 8'h00 : {5'b00000, ovf_m, (occ == 0), (occ >= EFF)};
      pend.push_back(p);
    end
    if (wr && !a) addr_m = d;
    if (wr && a) begin
      if (occ - credit < EFF) begin
        ent_t e;
        e.push_t  = c;
        e.issue_t = (c + 2 > last_issue + W) ? c + 2 : last_issue + W;
        e.a       = addr_m;
        e.d       = d;
        last_issue = e.issue_t;
        q.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) ovf_m = 1'b1;
    else if (rd && !a) ovf_m = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_status(input string nm, input logic [7:0] exp);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk(nm, 32'(bus.dout), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.host_wr = 1'b0;
    bus.host_rd = 1'b0;
    bus.a0      = 1'b0;
    bus.din     = 8'h00;
    q.delete();
    pend.delete();
    last_issue = -100000;
    addr_m     = 8'h00;
    ovf_m      = 1'b0;
    dout_exp   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_reg_wr", {15'b0, bus.opl2_reg_wr}, 32'h0);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    reset = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin : cmp
      bit   found;
      ent_t e;
      found = 1'b0;
      foreach (q[i]) if (q[i].issue_t == cyc) begin found = 1'b1; e = q[i]; end
      while (pend.size() > 0 && pend[0].at <= cyc) begin
        dout_exp = pend[0].v;
        void'(pend.pop_front());
      end
      chk("reg_wr_valid", 32'(bus.opl2_reg_wr.valid), 32'(found));
      if (found) begin
        chk("reg_wr_address", 32'(bus.opl2_reg_wr.address), 32'(e.a));
        chk("reg_wr_data", 32'(bus.opl2_reg_wr.data), 32'(e.d));
      end
      if (bus.opl2_reg_wr.valid === 1'b1) begin
        pulse_t.push_back(cyc);
        pulse_d.push_back(bus.opl2_reg_wr.data);
      end
      chk("dout", 32'(bus.dout), 32'(dout_exp));
    end
  end

  initial begin
    int base;
    int n;
    int exp_n;
    logic [7:0] exp_d[$];

    bus.host_wr = 1'b0;
    bus.host_rd = 1'b0;
    bus.a0      = 1'b0;
    bus.din     = 8'h00;

    // Reset state and quiet output
    do_reset();
    read_status("t1_status_reset", 8'h02);
    base = pulse_t.size();
    idle(100);
    chk("t1_no_pulses", 32'(pulse_t.size() - base), 32'd0);

    // Single write: pulse two clocks after the data strobe
    step(1'b1, 1'b0, 1'b0, 8'hC3);
    base = pulse_t.size();
    step(1'b1, 1'b0, 1'b1, 8'h01);
    idle(2);
    chk("t2_valid", 32'(bus.opl2_reg_wr.valid), 32'd1);
    chk("t2_address", 32'(bus.opl2_reg_wr.address), 32'hC3);
    chk("t2_data", 32'(bus.opl2_reg_wr.data), 32'h01);
    idle(40);
    chk("t2_one_pulse", 32'(pulse_t.size() - base), 32'd1);
    chk("t2_addr_hold", 32'(bus.opl2_reg_wr.address), 32'hC3);

    // Back-to-back data writes, fill to full, overflow, ovf clear on read
    step(1'b1, 1'b0, 1'b0, 8'hA0);
    base = pulse_t.size();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
    read_status("t3_status_full", HOLD ? 8'h05 : 8'h01);
    step(1'b1, 1'b0, 1'b1, 8'h19);
    read_status("t3_status_ovf", 8'h05);
    read_status("t3_status_ovf_cleared", 8'h01);
    idle(330);
    exp_d.delete();
    if (HOLD) begin
      exp_d.push_back(8'h10);
      exp_d.push_back(8'h12);
    end else begin
      for (int i = 0; i < 9; i++) exp_d.push_back(8'(8'h10 + i));
    end
    exp_n = exp_d.size();
    n = pulse_t.size() - base;
    chk("t3_npulses", 32'(n), 32'(exp_n));
    for (int k = 0; k < n && k < exp_n; k++) begin
      chk("t3_pulse_data", 32'(pulse_d[base + k]), 32'(exp_d[k]));
      if (k > 0) chk("t3_spacing", 32'(pulse_t[base + k] - pulse_t[base + k - 1]), 32'd32);
    end
    read_status("t3_status_drained", 8'h02);

    // Reset mid-drain discards the queue
    step(1'b1, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
    idle(3);
    do_reset();
    base = pulse_t.size();
    read_status("t4_status_after_reset", 8'h02);
    idle(60);
    chk("t4_no_pulses", 32'(pulse_t.size() - base), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h66);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    idle(2);
    chk("t4_valid", 32'(bus.opl2_reg_wr.valid), 32'd1);
    chk("t4_address", 32'(bus.opl2_reg_wr.address), 32'h66);
    chk("t4_data", 32'(bus.opl2_reg_wr.data), 32'h77);
    idle(40);

    // Two data writes one clock apart
    step(1'b1, 1'b0, 1'b0, 8'h12);
    base = pulse_t.size();
    step(1'b1, 1'b0, 1'b1, 8'h34);
    step(1'b1, 1'b0, 1'b1, 8'h56);
    idle(80);
    chk("t5_npulses", 32'(pulse_t.size() - base), HOLD ? 32'd1 : 32'd2);
    read_status("t5_status", HOLD ? 8'h06 : 8'h02);
    read_status("t5_status_again", 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
